// File: rtl/fp_mult_pkg.sv
// Shared types and defaults for the two-requester FP multiplier scheduler.
package fp_mult_pkg;

   localparam int DEF_LAT   = 3;
   localparam int DEF_DEPTH = 4;

   // Total IEEE-style word width: sign + exponent + mantissa.
   function automatic int fp_width(input int sig_w, input int ex_w);
      return sig_w + ex_w + 1;
   endfunction

   typedef logic tag_t;

   typedef struct packed {
      logic valid;
      tag_t tag;
   } pipe_entry_t;

endpackage

// File: rtl/fp_rsp_fifo.sv
// Per-requester result FIFO: registered storage, head shown directly, no bypass.
module fp_rsp_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [W-1:0]  push_data_i,
   input  logic          pop_i,
   output logic          valid_o,
   output logic [W-1:0]  data_o,
   output logic [CW-1:0] count_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   // A push at full is only legal when the head leaves in the same cycle.
   assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      if (!do_push && do_pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) mem_q[wr_ptr_q] <= push_data_i;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign valid_o = (count_q != '0);
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fp_mult_sched.sv
// Round-robin, credit-gated scheduler sharing one fixed-latency FP multiplier
// between two requesters, with in-order per-requester result FIFOs.
module fp_mult_sched
   import fp_mult_pkg::*;
#(
   parameter int sig_width = 23,
   parameter int ex_width  = 8,
   parameter int LAT       = DEF_LAT,
   parameter int DEPTH     = DEF_DEPTH,
   localparam int W        = fp_width(sig_width, ex_width)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [1:0][W-1:0] req_a,
   input  logic [1:0][W-1:0] req_b,
   output logic              mul_valid,
   output logic [W-1:0]      mul_a,
   output logic [W-1:0]      mul_b,
   input  logic              mul_res_valid,
   input  logic [W-1:0]      mul_res,
   output logic [1:0]        rsp_valid,
   input  logic [1:0]        rsp_ready,
   output logic [1:0][W-1:0] rsp_data,
   output logic              busy,
   output logic              proto_err
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   tag_t          ptr_q, ptr_d;
   logic          mul_valid_q;
   logic [W-1:0]  mul_a_q, mul_b_q;
   logic          proto_q, proto_d;
   pipe_entry_t   pipe_q [LAT+1];
   pipe_entry_t   ret;
   logic [CW-1:0] inflight_q [2];
   logic [CW-1:0] inflight_d [2];
   logic [CW-1:0] fifo_cnt [2];
   logic [CW-1:0] credit [2];
   logic [1:0]    elig, grant, push;
   logic          hs, res_wr, busy_c;
   tag_t          hs_tag;

   // Credit covers both queued and in-flight results, so a FIFO can never overflow.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         credit[i] = FULL - fifo_cnt[i] - inflight_q[i];
         elig[i]   = req_valid[i] && (credit[i] != '0);
      end
   end

   always_comb begin
      grant = '0;
      if (rst_n) begin
         if (elig[ptr_q])       grant[ptr_q]  = 1'b1;
         else if (elig[~ptr_q]) grant[~ptr_q] = 1'b1;
      end
   end

   assign hs        = |grant;
   assign hs_tag    = grant[1];
   assign req_ready = grant;
   assign ptr_d     = hs ? ~hs_tag : ptr_q;

   // The last pipeline stage lines up with the cycle the multiplier result is due.
   assign ret     = pipe_q[LAT];
   assign res_wr  = ret.valid && mul_res_valid;
   assign proto_d = proto_q || (mul_res_valid != ret.valid);

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         push[i]       = res_wr && (ret.tag == 1'(i));
         inflight_d[i] = inflight_q[i] + CW'(grant[i])
                         - CW'(ret.valid && (ret.tag == 1'(i)));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         mul_valid_q <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         proto_q     <= 1'b0;
         for (int k = 0; k <= LAT; k++) pipe_q[k] <= '0;
         for (int i = 0; i < 2; i++) inflight_q[i] <= '0;
      end else begin
         ptr_q       <= ptr_d;
         mul_valid_q <= hs;
         if (hs) begin
            mul_a_q <= req_a[hs_tag];
            mul_b_q <= req_b[hs_tag];
         end
         pipe_q[0] <= '{valid: hs, tag: hs_tag};
         for (int k = 1; k <= LAT; k++) pipe_q[k] <= pipe_q[k-1];
         proto_q <= proto_d;
         for (int i = 0; i < 2; i++) inflight_q[i] <= inflight_d[i];
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_fifo
      fp_rsp_fifo #(
         .W     (W),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk         (clk),
         .rst_n       (rst_n),
         .push_i      (push[g]),
         .push_data_i (mul_res),
         .pop_i       (rsp_ready[g]),
         .valid_o     (rsp_valid[g]),
         .data_o      (rsp_data[g]),
         .count_o     (fifo_cnt[g])
      );
   end

   always_comb begin
      busy_c = mul_valid_q || (|rsp_valid);
      for (int k = 0; k <= LAT; k++) busy_c = busy_c || pipe_q[k].valid;
   end

   assign mul_valid = mul_valid_q;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign busy      = busy_c;
   assign proto_err = proto_q;

endmodule

// File: tb/tb_fp_mult_sched.sv
// Directed bench for fp_mult_sched: table-driven multiplier model plus
// per-requester expected-result queues checked by an independent monitor.
module tb_fp_mult_sched;
  localparam int W = 32;
  localparam int LAT = 3;
  localparam int NV = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready;
  logic [1:0][W-1:0] req_a = '0;
  logic [1:0][W-1:0] req_b = '0;
  logic mul_valid;
  logic [W-1:0] mul_a, mul_b;
  logic mul_res_valid = 1'b0;
  logic [W-1:0] mul_res = '0;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready = 2'b11;
  logic [1:0][W-1:0] rsp_data;
  logic busy, proto_err;

  fp_mult_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
    .mul_res_valid(mul_res_valid), .mul_res(mul_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .proto_err(proto_err)
  );

  // clock / reset
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // vector table: a, b, hand-computed single-precision product
  logic [W-1:0] va [NV];
  logic [W-1:0] vb [NV];
  logic [W-1:0] vp [NV];

  int checks = 0;
  int errors = 0;
  int pend0[$];
  int pend1[$];
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int grant_log[$];
  logic [1:0] en = '0;
  logic [1:0] rr = 2'b11;
  logic [1:0] skip = '0;
  logic drop_next = 1'b0;
  logic spur_req = 1'b0;
  logic clr_model = 1'b1;
  logic line_v [LAT];
  logic [W-1:0] line_d [LAT];
  logic cap_v = 1'b0;
  logic [W-1:0] cap_d = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int k = 0; k < NV; k++)
      if (va[k] == a && vb[k] == b) return vp[k];
    return 32'hDEAD_BEEF;
  endfunction

  // driver: all bench-driven DUT inputs change only #1 after the rising edge
  always @(posedge clk) begin
    #1;
    req_valid[0] = en[0] && (pend0.size() > 0);
    req_valid[1] = en[1] && (pend1.size() > 0);
    req_a[0] = (pend0.size() > 0) ? va[pend0[0]] : '0;
    req_b[0] = (pend0.size() > 0) ? vb[pend0[0]] : '0;
    req_a[1] = (pend1.size() > 0) ? va[pend1[0]] : '0;
    req_b[1] = (pend1.size() > 0) ? vb[pend1[0]] : '0;
    rsp_ready = rr;
    if (clr_model) begin
      for (int k = 0; k < LAT; k++) begin
        line_v[k] = 1'b0;
        line_d[k] = '0;
      end
      clr_model = 1'b0;
    end else begin
      for (int k = LAT - 1; k > 0; k--) begin
        line_v[k] = line_v[k-1];
        line_d[k] = line_d[k-1];
      end
      line_v[0] = cap_v;
      line_d[0] = cap_d;
    end
    mul_res_valid = line_v[LAT-1] | spur_req;
    mul_res = line_d[LAT-1];
    spur_req = 1'b0;
  end

  // multiplier model capture
  always @(negedge clk) begin
    cap_v = mul_valid;
    cap_d = model_mul(mul_a, mul_b);
    if (cap_v && drop_next) begin
      cap_v = 1'b0;
      drop_next = 1'b0;
    end
  end

  // handshake recorder and scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_ready != 2'b00) chk("ready_onehot", W'($onehot(req_ready)), W'(1));
      if (req_valid[0] && req_ready[0]) begin
        grant_log.push_back(0);
        if (skip[0]) skip[0] = 1'b0;
        else exp_q0.push_back(vp[pend0[0]]);
        void'(pend0.pop_front());
      end
      if (req_valid[1] && req_ready[1]) begin
        grant_log.push_back(1);
        if (skip[1]) skip[1] = 1'b0;
        else exp_q1.push_back(vp[pend1[0]]);
        void'(pend1.pop_front());
      end
      if (rsp_valid[0] && rsp_ready[0]) begin
        if (exp_q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp0_unexpected actual=%h expected=none", rsp_data[0]);
        end else chk("rsp0_data", rsp_data[0], exp_q0.pop_front());
      end
      if (rsp_valid[1] && rsp_ready[1]) begin
        if (exp_q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp1_unexpected actual=%h expected=none", rsp_data[1]);
        end else chk("rsp1_data", rsp_data[1], exp_q1.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, W'(req_ready), W'(0));
    chk({tag, "_mul_valid"}, W'(mul_valid), W'(0));
    chk({tag, "_mul_a"}, mul_a, '0);
    chk({tag, "_mul_b"}, mul_b, '0);
    chk({tag, "_rsp_valid"}, W'(rsp_valid), W'(0));
    chk({tag, "_rsp_data0"}, rsp_data[0], '0);
    chk({tag, "_rsp_data1"}, rsp_data[1], '0);
    chk({tag, "_busy"}, W'(busy), W'(0));
    chk({tag, "_proto_err"}, W'(proto_err), W'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = '0;
    pend0.delete(); pend1.delete();
    exp_q0.delete(); exp_q1.delete();
    grant_log.delete();
    skip = '0; drop_next = 1'b0; clr_model = 1'b1;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int t;
    t = 0;
    while ((busy || pend0.size() > 0 || pend1.size() > 0 ||
            exp_q0.size() > 0 || exp_q1.size() > 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= budget) begin
      errors++;
      $display("FAIL %s drain timeout busy=%0b pend=%0d/%0d exp=%0d/%0d", name, busy,
               pend0.size(), pend1.size(), exp_q0.size(), exp_q1.size());
    end
  endtask

  initial begin
    int t, n1;
    va[0] = 32'h3FC0_0000; vb[0] = 32'h4000_0000; vp[0] = 32'h4040_0000; // 1.5*2=3
    va[1] = 32'h4000_0000; vb[1] = 32'h4000_0000; vp[1] = 32'h4080_0000; // 2*2=4
    va[2] = 32'h3F80_0000; vb[2] = 32'h4120_0000; vp[2] = 32'h4120_0000; // 1*10=10
    va[3] = 32'h4040_0000; vb[3] = 32'h40A0_0000; vp[3] = 32'h4170_0000; // 3*5=15
    va[4] = 32'hBF80_0000; vb[4] = 32'h4000_0000; vp[4] = 32'hC000_0000; // -1*2=-2
    va[5] = 32'h3F00_0000; vb[5] = 32'h3F00_0000; vp[5] = 32'h3E80_0000; // .5*.5=.25
    va[6] = 32'h4080_0000; vb[6] = 32'h3E80_0000; vp[6] = 32'h3F80_0000; // 4*.25=1
    va[7] = 32'h4100_0000; vb[7] = 32'h40E0_0000; vp[7] = 32'h4260_0000; // 8*7=56

    // reset with both requesters presenting work: every output must stay 0
    pend0.push_back(0); pend1.push_back(1); en = 2'b11;
    cyc(3);
    chk_zero("reset");
    en = '0; pend0.delete(); pend1.delete();
    rst_n = 1'b1;
    cyc(2);

    // single op on requester 0, latency check
    pend0.push_back(0); en = 2'b01;
    t = 0;
    while (!(req_valid[0] && req_ready[0]) && t < 20) begin @(negedge clk); t++; end
    chk("single_hs_seen", W'(t < 20), W'(1));
    cyc(1);
    chk("single_mul_valid", W'(mul_valid), W'(1));
    chk("single_mul_a", mul_a, 32'h3FC0_0000);
    chk("single_mul_b", mul_b, 32'h4000_0000);
    cyc(1);
    chk("single_mul_valid_drop", W'(mul_valid), W'(0));
    cyc(2);
    chk("single_rsp_early", W'(rsp_valid), W'(0));
    cyc(1);
    chk("single_rsp_valid", W'(rsp_valid), W'(2'b01));
    chk("single_rsp_data0", rsp_data[0], 32'h4040_0000);
    wait_idle(50, "single");

    // both requesters continuously valid: grants alternate from requester 0
    do_reset();
    for (int k = 0; k < 4; k++) begin pend0.push_back(k); pend1.push_back(k + 4); end
    en = 2'b11;
    t = 0;
    while ((pend0.size() > 0 || pend1.size() > 0) && t < 40) begin @(negedge clk); t++; end
    chk("alt_grant_count", W'(grant_log.size()), W'(8));
    for (int k = 0; k < 8 && k < grant_log.size(); k++)
      chk("alt_grant_order", W'(grant_log[k]), W'(k % 2));
    wait_idle(60, "alternate");

    // backpressure on requester 1: exactly four accepts, requester 0 keeps going
    do_reset();
    rr = 2'b01;
    for (int k = 0; k < 6; k++) begin pend0.push_back(k); pend1.push_back(7 - k); end
    en = 2'b11;
    cyc(30);
    n1 = 0;
    foreach (grant_log[k]) if (grant_log[k] == 1) n1++;
    chk("bp_req1_accepts", W'(n1), W'(4));
    chk("bp_req0_done", W'(pend0.size()), W'(0));
    chk("bp_req1_valid", W'(req_valid[1]), W'(1));
    chk("bp_req1_ready", W'(req_ready[1]), W'(0));
    chk("bp_rsp1_valid", W'(rsp_valid[1]), W'(1));
    rr = 2'b11;
    wait_idle(100, "backpressure");

    // refill requester 1 then pop intermittently while results keep arriving
    rr = 2'b01;
    for (int k = 0; k < 8; k++) pend1.push_back(k);
    en = 2'b10;
    cyc(15);
    chk("fill_pending", W'(pend1.size()), W'(4));
    for (int k = 0; k < 40; k++) begin
      rr = {k[0], 1'b1};
      @(negedge clk);
    end
    rr = 2'b11;
    wait_idle(100, "full_pushpop");

    // dropped result, then a spurious strobe: sticky error, credits recover
    do_reset();
    chk("proto_clear", W'(proto_err), W'(0));
    drop_next = 1'b1; skip = 2'b01;
    pend0.push_back(0); en = 2'b01;
    cyc(12);
    chk("drop_proto_err", W'(proto_err), W'(1));
    chk("drop_no_rsp", W'(rsp_valid), W'(0));
    chk("drop_not_busy", W'(busy), W'(0));
    spur_req = 1'b1;
    cyc(5);
    chk("spur_proto_sticky", W'(proto_err), W'(1));
    chk("spur_discarded", W'(rsp_valid), W'(0));
    rr = 2'b10;
    for (int k = 1; k < 6; k++) pend0.push_back(k);
    cyc(15);
    chk("credit_recover_accepts", W'(pend0.size()), W'(1));
    chk("credit_recover_ready", W'(req_ready[0]), W'(0));
    rr = 2'b11;
    wait_idle(60, "proto");
    chk("proto_still_set", W'(proto_err), W'(1));

    // reset with three ops in flight
    do_reset();
    pend0.push_back(0); pend0.push_back(1); pend1.push_back(2);
    en = 2'b11;
    t = 0;
    while (grant_log.size() < 3 && t < 20) begin @(negedge clk); t++; end
    chk("mid_three_issued", W'(grant_log.size()), W'(3));
    cyc(1);
    #1 rst_n = 1'b0;
    #1 chk_zero("rst_mid");
    exp_q0.delete(); exp_q1.delete(); grant_log.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_mid_busy", W'(busy), W'(0));
    cyc(6);
    chk("late_result_proto", W'(proto_err), W'(1));
    chk("late_result_no_rsp", W'(rsp_valid), W'(0));
    do_reset();
    rr = 2'b10;
    for (int k = 0; k < 5; k++) pend0.push_back(k);
    pend1.push_back(5);
    en = 2'b11;
    cyc(15);
    chk("post_rst_first_grant", W'((grant_log.size() > 0) ? grant_log[0] : 9), W'(0));
    chk("post_rst_credits", W'(pend0.size()), W'(1));
    rr = 2'b11;
    wait_idle(60, "post_reset");
    chk("post_rst_proto", W'(proto_err), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_mult_sched.md
FP_MULT_SCHED -- requirements
Module: fp_mult_sched

Interface
REQ-001 Parameters SHALL be: sig_width, default 23, mantissa field width; ex_width, default 8, exponent field width; LAT, default 3, fixed multiplier latency in cycles (valid range 1..8); DEPTH, default 4, per-requester result FIFO depth (power of 2, at least 2).
REQ-002 Width W SHALL equal sig_width+ex_width+1. Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  operand request valid, one bit per requester.
- req_ready  out  2  request accepted this cycle.
- req_a, req_b  in  2xW  operands per requester.
- mul_valid  out  1  issue to shared FP multiplier.
- mul_a, mul_b  out  W  operands to multiplier.
- mul_res_valid  in  1  multiplier result strobe.
- mul_res  in  W  multiplier result.
- rsp_valid  out  2  result available, per requester.
- rsp_ready  in  2  requester consumes result.
- rsp_data  out  2xW  result per requester.
- busy  out  1  any op in flight or any FIFO non-empty.
- proto_err  out  1  sticky; multiplier strobe mismatch.

Function
REQ-003 At most one request SHALL be accepted per cycle; req_ready SHALL be one-hot or zero.
REQ-004 Requester i SHALL be eligible only when req_valid[i]=1 and credit[i]>0, where credit[i] = DEPTH - fifo_count[i] - inflight[i].
REQ-005 Arbitration SHALL be round-robin: a pointer selects the preferred requester, and after every grant the pointer moves to the other requester. With no grant the pointer SHALL hold. The pointer SHALL reset to requester 0.
REQ-006 req_ready[i] MAY depend combinationally on req_valid; a handshake occurs when req_valid[i] and req_ready[i] are both 1.
REQ-007 A handshake in cycle t SHALL register mul_valid=1, mul_a and mul_b so they are visible in cycle t+1. mul_valid SHALL be 0 in cycles with no handshake in the prior cycle.
REQ-008 A LAT+1-deep valid/tag shift pipeline SHALL record each issue. The result of an issue in cycle t+1 SHALL be expected with mul_res_valid=1 in cycle t+1+LAT.
REQ-009 An expected result SHALL be written to the FIFO of its tagged requester at the end of that cycle, so rsp_valid rises no earlier than cycle t+2+LAT.
REQ-010 inflight[i] SHALL increment on handshake and decrement on FIFO write. Simultaneous increment and decrement SHALL leave inflight[i] unchanged.
REQ-011 A FIFO SHALL never overflow. Credit accounting guarantees space, and the multiplier is never stalled.
REQ-012 Per FIFO: rsp_valid[i] = non-empty, and rsp_data[i] = head. A pop occurs on rsp_valid and rsp_ready. A push and pop in the same cycle SHALL be legal at any count, including full and empty. A push to an empty FIFO SHALL appear on the next cycle, with no bypass.
REQ-013 Results for each requester SHALL be returned in acceptance order.
REQ-014 When mul_res_valid differs from the pipeline-expected valid in any cycle, proto_err SHALL set and stay set until reset. An unexpected result SHALL be discarded. A missing result SHALL still retire its inflight slot with no FIFO write.
REQ-015 busy SHALL be 1 when any pipeline stage is valid, mul_valid is 1, or any FIFO is non-empty.
REQ-016 All pointers and counters SHALL wrap modulo their power-of-2 range.

Reset
REQ-017 While rst_n=0, all outputs SHALL be 0: req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_data (registered head contents cleared), busy and proto_err.
REQ-018 Reset mid-operation SHALL discard in-flight ops and FIFO contents, zero all credits back to full, and reset the arbiter pointer to 0.
REQ-019 Results arriving after reset for discarded ops SHALL flag proto_err.

Structure
REQ-020 The shared package fp_mult_pkg SHALL hold W derivation, a requester tag typedef (1 bit), a pipeline-entry struct {valid, tag}, and default LAT/DEPTH constants.
REQ-021 The per-requester result FIFO SHALL be the sub-module fp_rsp_fifo, instantiated twice.
REQ-022 The arbiter, credit counters and tag pipeline SHALL stay in fp_mult_sched.

Verification
REQ-023 Single op: req0 with 0x3FC00000 x 0x40000000, model returns 0x40400000 -> mul_valid at t+1, rsp_valid[0] at t+5 (LAT=3) with 0x40400000, rsp_valid[1]=0.
REQ-024 Both requesters continuously valid -> grants alternate 0,1,0,1 starting with 0 after reset; per-requester results in order.
REQ-025 Backpressure: rsp_ready[1]=0, req1 always valid -> exactly DEPTH=4 accepts for requester 1, then req_ready[1]=0 while requester 0 continues. Releasing rsp_ready resumes issue with no overflow.
REQ-026 Full FIFO with simultaneous push and pop -> count stays 4 and data order is preserved.
REQ-027 Model drops one result, then injects a spurious strobe -> proto_err=1 and sticky; credits recover to 4.
REQ-028 Assert rst_n=0 with 3 ops in flight -> all outputs 0 immediately; after release, busy=0, full credits, pointer at requester 0.
